softmax_max_sub: RTL and testbench

SOFTMAX_MAX_SUB -- requirements
Module: softmax_max_sub

---
 rtl/softmax_pkg.sv | 18 +
 rtl/softmax_max_sub_if.sv | 41 ++++
 rtl/maxsub_buf.sv | 33 +++
 rtl/softmax_max_sub.sv | 164 ++++++++++++++++
 tb/tb_softmax_max_sub.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/softmax_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_pkg : shared defaults and FSM state type for softmax_max_sub       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package softmax_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int VEC_LEN_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/softmax_max_sub_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_max_sub_if : input/output stream bundle; max_data only present     |
// | with SOFTMAX_MAX_OUT_EN.  Rev 1.0                                          |
// +----------------------------------------------------------------------------+
interface softmax_max_sub_if
    import softmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef SOFTMAX_MAX_OUT_EN
    logic [DATA_W-1:0] max_data;
`endif

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
`ifdef SOFTMAX_MAX_OUT_EN
        , output max_data
`endif
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
`ifdef SOFTMAX_MAX_OUT_EN
        , input max_data
`endif
    );

endinterface
`default_nettype wire

// File: rtl/maxsub_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxsub_buf : VEC_LEN x DATA_W register file, sync write, comb read.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module maxsub_buf
    import softmax_pkg::*;
#(
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PTR_W   = $clog2(VEC_LEN)
) (
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic [PTR_W-1:0]  waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic [PTR_W-1:0]  raddr_i,
    output      logic [DATA_W-1:0] rdata_o
);

    // Contents are deliberately left unreset; every slot is written before it is read.
    logic [DATA_W-1:0] mem_q [VEC_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/softmax_max_sub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | softmax_max_sub : buffers a vector, tracks its signed max, then streams    |
// | max - x_i.  Option SOFTMAX_MAX_OUT_EN adds max_data.  Rev 1.0              |
// +----------------------------------------------------------------------------+
module softmax_max_sub
    import softmax_pkg::*;
#(
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         stage_run,
    output      logic         busy,
    softmax_max_sub_if.slave  bus
);

    localparam int               PTR_W     = $clog2(VEC_LEN);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(VEC_LEN - 1);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  last_idx_q, last_idx_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
`ifdef SOFTMAX_MAX_OUT_EN
    logic [DATA_W-1:0] max_out_q, max_out_d;
`endif

    logic              in_fire, out_fire, first_elem, close_vec;
    logic [DATA_W-1:0] max_new, head_val, rd_data;
    logic [PTR_W-1:0]  rd_next, rd_addr;

    // One extra bit keeps max - x exact; the true result is never negative.
    function automatic logic [DATA_W-1:0] diff(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] wide;
        wide = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
        return wide[DATA_W-1:0];
    endfunction

    assign bus.in_ready = reset && (state_q != S_DRAIN);
    assign in_fire      = bus.in_valid && bus.in_ready && stage_run;
    assign out_fire     = out_valid_q && bus.out_ready && stage_run;
    assign first_elem   = (state_q == S_IDLE);
    assign close_vec    = bus.in_last || (wr_ptr_q == LAST_SLOT);
    assign max_new      = (first_elem || ($signed(bus.in_data) > $signed(max_q)))
                          ? bus.in_data : max_q;
    assign rd_next      = rd_ptr_q + 1'b1;
    // Outside DRAIN the read port looks at slot 0 so the first difference can be
    // registered on the closing transfer; inside DRAIN it prefetches the next slot.
    assign rd_addr      = (state_q == S_DRAIN && rd_ptr_q != last_idx_q) ? rd_next : '0;
    assign head_val     = first_elem ? bus.in_data : rd_data;

    maxsub_buf #(
        .VEC_LEN (VEC_LEN),
        .DATA_W  (DATA_W),
        .PTR_W   (PTR_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (in_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.in_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_idx_d  = last_idx_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef SOFTMAX_MAX_OUT_EN
        max_out_d   = max_out_q;
`endif
        unique case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_fire) begin
                    max_d = max_new;
                    if (close_vec) begin
                        last_idx_d  = wr_ptr_q;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        state_d     = S_DRAIN;
                        out_valid_d = 1'b1;
                        out_data_d  = diff(max_new, head_val);
                        out_last_d  = (wr_ptr_q == '0);
`ifdef SOFTMAX_MAX_OUT_EN
                        max_out_d   = max_new;
`endif
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (rd_ptr_q == last_idx_q) begin
                        rd_ptr_d    = '0;
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
`ifdef SOFTMAX_MAX_OUT_EN
                        max_out_d   = '0;
`endif
                    end else begin
                        rd_ptr_d   = rd_next;
                        out_data_d = diff(max_q, rd_data);
                        out_last_d = (rd_next == last_idx_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_idx_q  <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef SOFTMAX_MAX_OUT_EN
            max_out_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_idx_q  <= last_idx_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef SOFTMAX_MAX_OUT_EN
            max_out_q   <= max_out_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != S_IDLE);
`ifdef SOFTMAX_MAX_OUT_EN
    assign bus.max_data  = max_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_max_sub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_softmax_max_sub : directed scoreboard bench for softmax_max_sub.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_softmax_max_sub;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic stage_run;
    logic busy;

    int errors = 0;
    int checks = 0;

    exp_t        sb[$];
    logic [31:0] vec[$];

    logic        hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    softmax_max_sub_if #(.DATA_W(32)) ifc ();

    softmax_max_sub #(
        .VEC_LEN (8),
        .DATA_W  (32)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .stage_run (stage_run),
        .busy      (busy),
        .bus       (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks that a
    // stalled output holds its value.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", {31'd0, ifc.out_valid}, 32'd1);
                chk("hold_data", ifc.out_data, hold_data);
                chk("hold_last", {31'd0, ifc.out_last}, {31'd0, hold_last});
            end
            if (ifc.out_valid && ifc.out_ready && stage_run) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {31'd0, ifc.out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", ifc.out_data, e.data);
                    chk("out_last", {31'd0, ifc.out_last}, {31'd0, e.last});
`ifdef SOFTMAX_MAX_OUT_EN
                    chk("max_data", ifc.max_data, e.mx);
`endif
                end
            end
            hold_pend = ifc.out_valid && !(ifc.out_ready && stage_run);
            hold_data = ifc.out_data;
            hold_last = ifc.out_last;
        end
    end

    task automatic put(input logic [31:0] d, input logic l);
        bit done;
        done = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = l;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ifc.in_ready && stage_run) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    // Pushes expectations for vec, then streams it in.
    task automatic run_vec(input bit mark_last);
        logic [31:0] mx;
        longint      d;
        exp_t        e;
        mx = vec[0];
        foreach (vec[i]) if ($signed(vec[i]) > $signed(mx)) mx = vec[i];
        foreach (vec[i]) begin
            d      = longint'($signed(mx)) - longint'($signed(vec[i]));
            e.data = d[31:0];
            e.last = (i == vec.size() - 1);
            e.mx   = mx;
            sb.push_back(e);
        end
        foreach (vec[i]) put(vec[i], mark_last && (i == vec.size() - 1));
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        chk("first_valid_latency", {31'd0, ifc.out_valid}, 32'd1);
        chk("in_ready_drain", {31'd0, ifc.in_ready}, 32'd0);
    endtask

    task automatic wait_drain(input bit rnd);
        bit drained;
        drained = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !ifc.out_valid) begin
                drained = 1'b1;
                break;
            end
            if (rnd) begin
                ifc.out_ready = 1'($urandom_range(0, 1));
                stage_run     = !(c >= 4 && c < 7);
            end
        end
        stage_run     = 1'b1;
        ifc.out_ready = 1'b1;
        chk("drain_leftover", sb.size(), 32'd0);
        chk("drained", {31'd0, drained}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_in_ready", {31'd0, ifc.in_ready}, 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        stage_run     = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_out_data", ifc.out_data, 32'd0);
        chk("rst_out_last", {31'd0, ifc.out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);

        // Basic vector: expected {7,15,0,12}.
        vec = '{32'd5, 32'hFFFF_FFFD, 32'd12, 32'd0};
        run_vec(1'b1);
        wait_drain(1'b0);

        // Extremes: expected {0, FFFFFFFF}.
        vec = '{32'h7FFF_FFFF, 32'h8000_0000};
        run_vec(1'b1);
        wait_drain(1'b0);

        // Forced close on the eighth element, no in_last.
        vec = '{32'd3, 32'hFFFF_FF9C, 32'd40, 32'd40, 32'd0, 32'hFFFF_FFFF, 32'd39, 32'd100};
        run_vec(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("forced_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("forced_busy", {31'd0, busy}, 32'd1);
        wait_drain(1'b0);

        // Backpressure and a stage_run stall during drain.
        ifc.out_ready = 1'b0;
        vec = '{32'd10, 32'hFFFF_FFF6, 32'd25, 32'd7, 32'd25, 32'hFFFF_FF00};
        run_vec(1'b1);
        wait_drain(1'b1);

        // Single-element vector.
        vec = '{32'hFFFF_FFF9};
        run_vec(1'b1);
        wait_drain(1'b0);

        // Async reset mid-LOAD discards the partial vector.
        put(32'd10, 1'b0);
        put(32'd20, 1'b0);
        ifc.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk("abort_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vec = '{32'd1, 32'd2};
        run_vec(1'b1);
        wait_drain(1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("final_out_valid", {31'd0, ifc.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
